// File: rtl/afu_arb_if.sv
// rtl/afu_arb_if.sv - cpu_params_pkg ALU types/widths and the AFU_intf operand/result bus
package cpu_params_pkg;
    localparam int RSZ   = 32;
    localparam int PC_SZ = 32;

    typedef enum logic [2:0] {
        AM_RS1  = 3'd0,
        AM_RS2  = 3'd1,
        AM_IMM  = 3'd2,
        AM_PC   = 3'd3,
        AM_ZERO = 3'd4
    } ALU_SEL_TYPE;

    typedef enum logic [3:0] {
        A_ADD  = 4'd0,
        A_SUB  = 4'd1,
        A_AND  = 4'd2,
        A_OR   = 4'd3,
        A_XOR  = 4'd4,
        A_SLT  = 4'd5,
        A_SLTU = 4'd6,
        A_SLL  = 4'd7,
        A_SRL  = 4'd8,
        A_SRA  = 4'd9
    } ALU_OP_TYPE;
endpackage

interface AFU_intf;
    import cpu_params_pkg::*;

    logic [RSZ-1:0]   Rs1_data;
    logic [RSZ-1:0]   Rs2_data;
    logic [RSZ-1:0]   imm;
    logic [PC_SZ-1:0] pc;
    ALU_SEL_TYPE      sel_x;
    ALU_SEL_TYPE      sel_y;
    ALU_OP_TYPE       op;
    logic [RSZ-1:0]   Rd_data;

    modport master (output Rs1_data, Rs2_data, imm, pc, sel_x, sel_y, op, input Rd_data);
    modport slave  (input Rs1_data, Rs2_data, imm, pc, sel_x, sel_y, op, output Rd_data);
endinterface

// File: rtl/afu_arb.sv
// rtl/afu_arb.sv - two-requester round-robin front end for a shared ALU with a one-entry result register
// Optional grant counters are built only when AFU_ARB_PERF_EN is defined.
module afu_arb
    import cpu_params_pkg::*;
#(
    parameter int RSZ   = cpu_params_pkg::RSZ,
    parameter int PC_SZ = cpu_params_pkg::PC_SZ
`ifdef AFU_ARB_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             clk_in,
    input  logic             reset_in,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  ALU_SEL_TYPE      req0_sel_x,
    input  ALU_SEL_TYPE      req0_sel_y,
    input  ALU_OP_TYPE       req0_op,
    input  logic [RSZ-1:0]   req0_rs1,
    input  logic [RSZ-1:0]   req0_rs2,
    input  logic [RSZ-1:0]   req0_imm,
    input  logic [PC_SZ-1:0] req0_pc,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  ALU_SEL_TYPE      req1_sel_x,
    input  ALU_SEL_TYPE      req1_sel_y,
    input  ALU_OP_TYPE       req1_op,
    input  logic [RSZ-1:0]   req1_rs1,
    input  logic [RSZ-1:0]   req1_rs2,
    input  logic [RSZ-1:0]   req1_imm,
    input  logic [PC_SZ-1:0] req1_pc,

    AFU_intf.master          afu_bus,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [RSZ-1:0]   rsp_data
`ifdef AFU_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t state, state_nxt;
    logic   last_grant;
    logic   can_accept;
    logic   win_valid;
    logic   win_id;
    logic   accept;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // win_id falls back to 0 when nobody is valid so requester 0 owns the idle bus.
    always_comb begin
        can_accept = (state == S_EMPTY) || rsp_ready;
        win_valid  = req0_valid || req1_valid;
        win_id     = req1_valid && (!req0_valid || !last_grant);
        accept     = can_accept && win_valid && !reset_in;
        req0_ready = accept && !win_id;
        req1_ready = accept && win_id;
        rsp_valid  = (state == S_FULL);

        state_nxt = state;
        case (state)
            S_EMPTY: if (accept) state_nxt = S_FULL;
            S_FULL:  if (rsp_ready && !accept) state_nxt = S_EMPTY;
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        afu_bus.Rs1_data = req0_rs1;
        afu_bus.Rs2_data = req0_rs2;
        afu_bus.imm      = req0_imm;
        afu_bus.pc       = req0_pc;
        afu_bus.sel_x    = req0_sel_x;
        afu_bus.sel_y    = req0_sel_y;
        afu_bus.op       = req0_op;
        if (win_id) begin
            afu_bus.Rs1_data = req1_rs1;
            afu_bus.Rs2_data = req1_rs2;
            afu_bus.imm      = req1_imm;
            afu_bus.pc       = req1_pc;
            afu_bus.sel_x    = req1_sel_x;
            afu_bus.sel_y    = req1_sel_y;
            afu_bus.op       = req1_op;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            rsp_data   <= afu_bus.Rd_data;
            rsp_id     <= win_id;
            last_grant <= win_id;
        end
    end

`ifdef AFU_ARB_PERF_EN
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready && !(&grant_cnt0)) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (req1_ready && !(&grant_cnt1)) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_afu_arb.sv
// tb/tb_afu_arb.sv - self-checking bench for afu_arb: vector table, corner sequences, randomized model compare
module tb_afu_arb;
    import cpu_params_pkg::*;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        ALU_OP_TYPE  op;
        ALU_SEL_TYPE sx;
        ALU_SEL_TYPE sy;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } req_t;

    typedef struct packed {
        logic        rst;
        logic        v0;
        req_t        r0;
        logic        v1;
        req_t        r1;
        logic        rr;
        logic        e_r0;
        logic        e_r1;
        logic        e_valid;
        logic        e_id;
        logic [31:0] e_data;
        logic        chk_data;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_in;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    ALU_SEL_TYPE req0_sel_x, req0_sel_y, req1_sel_x, req1_sel_y;
    ALU_OP_TYPE  req0_op, req1_op;
    logic [31:0] req0_rs1, req0_rs2, req0_imm, req0_pc;
    logic [31:0] req1_rs1, req1_rs2, req1_imm, req1_pc;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;
`ifdef AFU_ARB_PERF_EN
    logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    AFU_intf bus();

    function automatic logic [31:0] pick(input ALU_SEL_TYPE s, input logic [31:0] rs1,
                                         input logic [31:0] rs2, input logic [31:0] imm,
                                         input logic [31:0] pc);
        case (s)
            AM_RS1:  return rs1;
            AM_RS2:  return rs2;
            AM_IMM:  return imm;
            AM_PC:   return pc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] alu(input ALU_OP_TYPE op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            A_ADD:   return a + b;
            A_SUB:   return a - b;
            A_AND:   return a & b;
            A_OR:    return a | b;
            A_XOR:   return a ^ b;
            A_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            A_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            A_SLL:   return a << b[4:0];
            A_SRL:   return a >> b[4:0];
            A_SRA:   return $signed(a) >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] eval(input req_t r);
        return alu(r.op, pick(r.sx, r.rs1, r.rs2, r.imm, r.pc), pick(r.sy, r.rs1, r.rs2, r.imm, r.pc));
    endfunction

    // Stand-in for the shared ALU sitting on the far side of the bus.
    assign bus.Rd_data = alu(bus.op, pick(bus.sel_x, bus.Rs1_data, bus.Rs2_data, bus.imm, bus.pc),
                                     pick(bus.sel_y, bus.Rs1_data, bus.Rs2_data, bus.imm, bus.pc));

`ifdef AFU_ARB_PERF_EN
    afu_arb #(.CNT_W(CW)) dut (
        .clk_in(clk), .reset_in(reset_in),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel_x(req0_sel_x),
        .req0_sel_y(req0_sel_y), .req0_op(req0_op), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req0_imm(req0_imm), .req0_pc(req0_pc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel_x(req1_sel_x),
        .req1_sel_y(req1_sel_y), .req1_op(req1_op), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .req1_imm(req1_imm), .req1_pc(req1_pc),
        .afu_bus(bus),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );
`else
    afu_arb dut (
        .clk_in(clk), .reset_in(reset_in),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel_x(req0_sel_x),
        .req0_sel_y(req0_sel_y), .req0_op(req0_op), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req0_imm(req0_imm), .req0_pc(req0_pc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel_x(req1_sel_x),
        .req1_sel_y(req1_sel_y), .req1_op(req1_op), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .req1_imm(req1_imm), .req1_pc(req1_pc),
        .afu_bus(bus),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic v0, input req_t a, input logic v1,
                         input req_t b, input logic rr);
        reset_in   = rst;
        req0_valid = v0;  req0_op = a.op; req0_sel_x = a.sx; req0_sel_y = a.sy;
        req0_rs1 = a.rs1; req0_rs2 = a.rs2; req0_imm = a.imm; req0_pc = a.pc;
        req1_valid = v1;  req1_op = b.op; req1_sel_x = b.sx; req1_sel_y = b.sy;
        req1_rs1 = b.rs1; req1_rs2 = b.rs2; req1_imm = b.imm; req1_pc = b.pc;
        rsp_ready  = rr;
    endtask

    function automatic req_t mk(input ALU_OP_TYPE op, input ALU_SEL_TYPE sx, input ALU_SEL_TYPE sy,
                                input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        req_t r;
        r.op = op; r.sx = sx; r.sy = sy; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.pc = 32'h100;
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.op  = ALU_OP_TYPE'($urandom_range(0, 9));
        r.sx  = ALU_SEL_TYPE'($urandom_range(0, 4));
        r.sy  = ALU_SEL_TYPE'($urandom_range(0, 4));
        r.rs1 = $urandom; r.rs2 = $urandom; r.imm = $urandom; r.pc = $urandom;
        return r;
    endfunction

    function automatic vec_t row(input logic rst, input logic v0, input req_t r0, input logic v1,
                                 input req_t r1, input logic rr, input logic e0, input logic e1,
                                 input logic ev, input logic eid, input logic [31:0] ed, input logic ck);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.r0 = r0; v.v1 = v1; v.r1 = r1; v.rr = rr;
        v.e_r0 = e0; v.e_r1 = e1; v.e_valid = ev; v.e_id = eid; v.e_data = ed; v.chk_data = ck;
        return v;
    endfunction

    initial begin
        vec_t vt[22];
        req_t add57, add12, sub10, slt, nil;
        int   q_id[$];
        logic [31:0] q_dat[$];
        int   last, w, w_prev, c0, c1;
        logic rst, rst_prev, v0, v1, rr;
        req_t a, b;

        add57 = mk(A_ADD, AM_RS1, AM_IMM, 32'd5, 32'd0, 32'd7);
        add12 = mk(A_ADD, AM_RS1, AM_RS2, 32'd1, 32'd2, 32'd0);
        sub10 = mk(A_SUB, AM_RS1, AM_RS2, 32'd10, 32'd3, 32'd0);
        slt   = mk(A_SLT, AM_RS1, AM_RS2, 32'hFFFF_FFFF, 32'd1, 32'd0);
        nil   = mk(A_ADD, AM_RS1, AM_RS1, 32'd0, 32'd0, 32'd0);

        //           rst v0 r0     v1 r1     rr  e0 e1 ev id data  chk
        vt[0]  = row(1, 1, add57, 1, sub10, 1,  0, 0, 0, 0, 0,    1);
        vt[1]  = row(0, 1, add57, 0, nil,   1,  1, 0, 1, 0, 12,   1);
        vt[2]  = row(0, 0, nil,   0, nil,   1,  0, 0, 0, 0, 0,    0);
        vt[3]  = row(1, 0, nil,   0, nil,   1,  0, 0, 0, 0, 0,    1);
        vt[4]  = row(0, 1, add12, 1, sub10, 1,  1, 0, 1, 0, 3,    1);
        vt[5]  = row(0, 1, add12, 1, sub10, 1,  0, 1, 1, 1, 7,    1);
        vt[6]  = row(0, 1, add12, 1, sub10, 1,  1, 0, 1, 0, 3,    1);
        vt[7]  = row(0, 1, add12, 1, sub10, 1,  0, 1, 1, 1, 7,    1);
        vt[8]  = row(0, 0, nil,   1, slt,   0,  0, 0, 1, 1, 7,    1);
        vt[9]  = row(0, 0, nil,   1, slt,   0,  0, 0, 1, 1, 7,    1);
        vt[10] = row(0, 0, nil,   1, slt,   0,  0, 0, 1, 1, 7,    1);
        vt[11] = row(0, 0, nil,   1, slt,   1,  0, 1, 1, 1, 1,    1);
        vt[12] = row(0, 0, nil,   1, sub10, 1,  0, 1, 1, 1, 7,    1);
        vt[13] = row(0, 0, nil,   1, slt,   1,  0, 1, 1, 1, 1,    1);
        vt[14] = row(0, 0, nil,   0, nil,   0,  0, 0, 1, 1, 1,    1);
        vt[15] = row(1, 1, add12, 0, nil,   0,  0, 0, 0, 0, 0,    1);
        vt[16] = row(0, 1, add12, 1, sub10, 1,  1, 0, 1, 0, 3,    1);
        vt[17] = row(1, 0, nil,   0, nil,   1,  0, 0, 0, 0, 0,    1);
        vt[18] = row(0, 1, add12, 0, nil,   1,  1, 0, 1, 0, 3,    1);
        vt[19] = row(0, 0, nil,   1, sub10, 0,  0, 0, 1, 0, 3,    1);
        vt[20] = row(0, 0, nil,   0, nil,   1,  0, 0, 0, 0, 0,    0);
        vt[21] = row(0, 1, add12, 1, sub10, 1,  0, 1, 1, 1, 7,    1);

        apply(1'b1, 1'b0, nil, 1'b0, nil, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            apply(vt[i].rst, vt[i].v0, vt[i].r0, vt[i].v1, vt[i].r1, vt[i].rr);
            #2;
            chk($sformatf("vec%0d req0_ready", i), 32'(req0_ready), 32'(vt[i].e_r0));
            chk($sformatf("vec%0d req1_ready", i), 32'(req1_ready), 32'(vt[i].e_r1));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vt[i].e_valid));
            if (vt[i].e_valid || vt[i].chk_data) begin
                chk($sformatf("vec%0d rsp_id", i), 32'(rsp_id), 32'(vt[i].e_id));
                chk($sformatf("vec%0d rsp_data", i), rsp_data, vt[i].e_data);
            end
        end

`ifdef AFU_ARB_PERF_EN
        apply(1'b1, 1'b0, nil, 1'b0, nil, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'b1, add57, 1'b0, nil, 1'b1);
            @(negedge clk);
        end
        chk("perf grant_cnt0 saturated", 32'(grant_cnt0), 32'(CMAX));
        chk("perf grant_cnt1 idle", 32'(grant_cnt1), 32'd0);
`endif

        // Randomized phase: the model is an output queue plus "whose turn is it".
        apply(1'b1, 1'b0, nil, 1'b0, nil, 1'b1);
        @(negedge clk);
        last = 1; c0 = 0; c1 = 0; w_prev = -1; rst_prev = 1'b1;
        v0 = 1'b0; v1 = 1'b0; a = nil; b = nil;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!v0 || w_prev == 0 || rst_prev) begin
                v0 = ($urandom_range(0, 9) < 7); a = rnd_req();
            end else if ($urandom_range(0, 7) == 0) v0 = 1'b0;
            if (!v1 || w_prev == 1 || rst_prev) begin
                v1 = ($urandom_range(0, 9) < 7); b = rnd_req();
            end else if ($urandom_range(0, 7) == 0) v1 = 1'b0;
            rr = ($urandom_range(0, 3) != 0);
            apply(rst, v0, a, v1, b, rr);

            w = -1;
            if (!rst && (q_dat.size() == 0 || rr)) begin
                if (v0 && v1)  w = (last == 1) ? 0 : 1;
                else if (v0)   w = 0;
                else if (v1)   w = 1;
            end
            #2;
            chk("rnd req0_ready", 32'(req0_ready), (w == 0) ? 32'd1 : 32'd0);
            chk("rnd req1_ready", 32'(req1_ready), (w == 1) ? 32'd1 : 32'd0);
            @(posedge clk);
            @(negedge clk);

            if (rst) begin
                q_id.delete(); q_dat.delete(); last = 1; c0 = 0; c1 = 0;
            end else begin
                if (rr && q_dat.size() > 0) begin
                    void'(q_id.pop_front()); void'(q_dat.pop_front());
                end
                if (w >= 0) begin
                    q_id.push_back(w);
                    q_dat.push_back(eval(w == 0 ? a : b));
                    last = w;
                    if (w == 0 && c0 < CMAX) c0++;
                    if (w == 1 && c1 < CMAX) c1++;
                end
            end
            chk("rnd rsp_valid", 32'(rsp_valid), (q_dat.size() > 0) ? 32'd1 : 32'd0);
            if (q_dat.size() > 0) begin
                chk("rnd rsp_id", 32'(rsp_id), 32'(q_id[0]));
                chk("rnd rsp_data", rsp_data, q_dat[0]);
            end else if (rst) begin
                chk("rnd rsp_data after reset", rsp_data, 32'd0);
            end
`ifdef AFU_ARB_PERF_EN
            chk("rnd grant_cnt0", 32'(grant_cnt0), 32'(c0));
            chk("rnd grant_cnt1", 32'(grant_cnt1), 32'(c1));
`endif
            w_prev = w;
            rst_prev = rst;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
